cache_ctrl_assoc: RTL and testbench

//  Parametrised N-way set-associative cache controller FSM; successor of the direct-mapped controller.

---
 rtl/cache_ctrl_assoc.sv | 188 ++++++++++++++++++
 tb/tb_cache_ctrl_assoc.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_ctrl_assoc.sv
// N-way set-associative cache controller: hit/miss steering, victim writeback,
// pipelined line fill with decoupled read returns, optional write-no-allocate.
module cache_ctrl_assoc #(
    parameter int WORDS_PER_LINE = 4,
    parameter int NUM_WAYS       = 2,
    parameter int WRITE_ALLOCATE = 1,
    localparam int CW = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1,
    localparam int WW = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rd,
    input  logic                wr,
    input  logic [CW-1:0]       cpu_word,
    input  logic [NUM_WAYS-1:0] hit_way,
    input  logic [NUM_WAYS-1:0] valid_way,
    input  logic [NUM_WAYS-1:0] dirty_way,
    input  logic [WW-1:0]       lru_way,
    input  logic                mem_stall,
    input  logic                mem_rvalid,
    output logic                stall,
    output logic                cache_hit,
    output logic                done,
    output logic                comp,
    output logic                cache_wr,
    output logic                valid_in,
    output logic                dirty_in,
    output logic                data_src,
    output logic [WW-1:0]       way_sel,
    output logic [CW-1:0]       word_sel,
    output logic                lru_upd,
    output logic                mem_rd,
    output logic                mem_wr,
    output logic [CW-1:0]       mem_word,
    output logic                err
);

    typedef enum logic [2:0] {
        S_IDLE, S_WB, S_RQ, S_RW, S_CW, S_DN, S_WNA
    } state_t;

    localparam logic [CW-1:0] LAST = CW'(WORDS_PER_LINE - 1);

    state_t              state, state_nx;
    logic   [WW-1:0]     victim, vic_nx, hit_idx;
    logic                lat_wr;
    logic   [CW-1:0]     wb_cnt, iss_cnt, fil_cnt;
    logic   [NUM_WAYS-1:0] hit_vec;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            victim  <= '0;
            lat_wr  <= 1'b0;
            wb_cnt  <= '0;
            iss_cnt <= '0;
            fil_cnt <= '0;
        end else begin
            state <= state_nx;
            case (state)
                S_IDLE: begin
                    wb_cnt  <= '0;
                    iss_cnt <= '0;
                    fil_cnt <= '0;
                    if (state_nx != S_IDLE) begin
                        victim <= vic_nx;
                        lat_wr <= wr;
                    end
                end
                S_WB: if (!mem_stall) wb_cnt <= wb_cnt + 1'b1;
                S_RQ, S_RW: begin
                    if (state == S_RQ && !mem_stall) iss_cnt <= iss_cnt + 1'b1;
                    if (mem_rvalid) fil_cnt <= fil_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nx  = state;
        stall     = 1'b0;
        cache_hit = 1'b0;
        done      = 1'b0;
        comp      = 1'b0;
        cache_wr  = 1'b0;
        valid_in  = 1'b0;
        dirty_in  = 1'b0;
        data_src  = 1'b0;
        way_sel   = '0;
        word_sel  = '0;
        lru_upd   = 1'b0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_word  = '0;
        err       = 1'b0;
        hit_vec   = hit_way & valid_way;
        hit_idx   = '0;
        vic_nx    = lru_way;
        // descending scan so the lowest index wins
        for (int i = NUM_WAYS - 1; i >= 0; i--) begin
            if (hit_vec[i]) hit_idx = WW'(i);
            if (!valid_way[i]) vic_nx = WW'(i);
        end
        case (state)
            S_IDLE: begin
                word_sel = cpu_word;
                if (rd && wr) begin
                    err = 1'b1;
                end else if (rd || wr) begin
                    comp = 1'b1;
                    if (|hit_vec) begin
                        cache_hit = 1'b1;
                        done      = 1'b1;
                        lru_upd   = 1'b1;
                        way_sel   = hit_idx;
                        if (wr) begin
                            cache_wr = 1'b1;
                            dirty_in = 1'b1;
                            valid_in = 1'b1;
                        end
                    end else begin
                        stall = 1'b1;
                        if (wr && WRITE_ALLOCATE == 0)
                            state_nx = S_WNA;
                        else if (valid_way[vic_nx] && dirty_way[vic_nx])
                            state_nx = S_WB;
                        else
                            state_nx = S_RQ;
                    end
                end
            end
            S_WB: begin
                stall    = 1'b1;
                mem_wr   = 1'b1;
                way_sel  = victim;
                word_sel = wb_cnt;
                mem_word = wb_cnt;
                if (!mem_stall && wb_cnt == LAST) state_nx = S_RQ;
            end
            S_RQ, S_RW: begin
                stall = 1'b1;
                if (state == S_RQ) begin
                    mem_rd   = 1'b1;
                    mem_word = iss_cnt;
                    if (!mem_stall && iss_cnt == LAST) state_nx = S_RW;
                end
                if (mem_rvalid) begin
                    cache_wr = 1'b1;
                    data_src = 1'b1;
                    valid_in = 1'b1;
                    way_sel  = victim;
                    word_sel = fil_cnt;
                    if (fil_cnt == LAST) state_nx = lat_wr ? S_CW : S_DN;
                end
            end
            S_CW: begin
                stall    = 1'b1;
                cache_wr = 1'b1;
                valid_in = 1'b1;
                dirty_in = 1'b1;
                way_sel  = victim;
                word_sel = cpu_word;
                done     = 1'b1;
                lru_upd  = 1'b1;
                state_nx = S_IDLE;
            end
            S_DN: begin
                done     = 1'b1;
                lru_upd  = 1'b1;
                way_sel  = victim;
                state_nx = S_IDLE;
            end
            S_WNA: begin
                mem_wr   = 1'b1;
                mem_word = cpu_word;
                if (mem_stall) begin
                    stall = 1'b1;
                end else begin
                    done     = 1'b1;
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_cache_ctrl_assoc.sv
// Scoreboard bench for cache_ctrl_assoc: per-cycle expected output bundles
// queued by the stimulus, popped and compared by a negedge monitor.
module tb_cache_ctrl_assoc;

    typedef struct packed {
        logic       stall;
        logic       cache_hit;
        logic       done;
        logic       comp;
        logic       cache_wr;
        logic       valid_in;
        logic       dirty_in;
        logic       data_src;
        logic       way_sel;
        logic [1:0] word_sel;
        logic       lru_upd;
        logic       mem_rd;
        logic       mem_wr;
        logic [1:0] mem_word;
        logic       err;
    } exp_t;

    typedef struct {
        int   sel;
        int   id;
        exp_t e;
    } rec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       rd, wr;
    logic [1:0] cpu_word;
    logic [1:0] hit_way, valid_way, dirty_way;
    logic       lru_way;
    logic       mem_stall, mem_rvalid;

    logic       stall0, hit0, done0, comp0, cwr0, vin0, din0, src0, way0;
    logic [1:0] wsel0, mword0;
    logic       lru0, mrd0, mwr0, err0;
    logic       stall1, hit1, done1, comp1, cwr1, vin1, din1, src1, way1;
    logic [1:0] wsel1, mword1;
    logic       lru1, mrd1, mwr1, err1;

    exp_t act0, act1;
    rec_t q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   n_id  = 0;

    always #5 clk = ~clk;

    cache_ctrl_assoc #(.WORDS_PER_LINE(4), .NUM_WAYS(2), .WRITE_ALLOCATE(1)) dut0 (
        .clk(clk), .rst(rst), .rd(rd), .wr(wr), .cpu_word(cpu_word),
        .hit_way(hit_way), .valid_way(valid_way), .dirty_way(dirty_way),
        .lru_way(lru_way), .mem_stall(mem_stall), .mem_rvalid(mem_rvalid),
        .stall(stall0), .cache_hit(hit0), .done(done0), .comp(comp0),
        .cache_wr(cwr0), .valid_in(vin0), .dirty_in(din0), .data_src(src0),
        .way_sel(way0), .word_sel(wsel0), .lru_upd(lru0), .mem_rd(mrd0),
        .mem_wr(mwr0), .mem_word(mword0), .err(err0)
    );

    cache_ctrl_assoc #(.WORDS_PER_LINE(4), .NUM_WAYS(2), .WRITE_ALLOCATE(0)) dut1 (
        .clk(clk), .rst(rst), .rd(rd), .wr(wr), .cpu_word(cpu_word),
        .hit_way(hit_way), .valid_way(valid_way), .dirty_way(dirty_way),
        .lru_way(lru_way), .mem_stall(mem_stall), .mem_rvalid(mem_rvalid),
        .stall(stall1), .cache_hit(hit1), .done(done1), .comp(comp1),
        .cache_wr(cwr1), .valid_in(vin1), .dirty_in(din1), .data_src(src1),
        .way_sel(way1), .word_sel(wsel1), .lru_upd(lru1), .mem_rd(mrd1),
        .mem_wr(mwr1), .mem_word(mword1), .err(err1)
    );

    assign act0 = {stall0, hit0, done0, comp0, cwr0, vin0, din0, src0,
                   way0, wsel0, lru0, mrd0, mwr0, mword0, err0};
    assign act1 = {stall1, hit1, done1, comp1, cwr1, vin1, din1, src1,
                   way1, wsel1, lru1, mrd1, mwr1, mword1, err1};

    always @(negedge clk) begin
        if (q.size() > 0) begin
            rec_t r;
            exp_t a;
            r = q.pop_front();
            a = (r.sel == 1) ? act1 : act0;
            n_vec++;
            if (a !== r.e) begin
                n_err++;
                $display("FAIL vec%0d dut%0d got %h exp %h", r.id, r.sel, a, r.e);
            end
        end
    end

    task automatic step(input int sel, input exp_t e);
        rec_t r;
        r.sel = sel;
        r.id  = n_id++;
        r.e   = e;
        q.push_back(r);
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        rd = 0; wr = 0; cpu_word = 0;
        hit_way = 0; valid_way = 0; dirty_way = 0; lru_way = 0;
        mem_stall = 0; mem_rvalid = 0;
    endtask

    task automatic do_reset();
        rst = 0;
        clr_in();
        step(0, '0);
        rst = 1;
        step(0, '0);
    endtask

    function automatic exp_t f_miss(input logic [1:0] w);
        exp_t e = '0;
        e.comp = 1; e.word_sel = w; e.stall = 1;
        return e;
    endfunction

    function automatic exp_t f_fill(input logic way, input logic [1:0] w);
        exp_t e = '0;
        e.stall = 1; e.cache_wr = 1; e.data_src = 1; e.valid_in = 1;
        e.way_sel = way; e.word_sel = w;
        return e;
    endfunction

    function automatic exp_t f_rq(input logic [1:0] iw, input logic fill,
                                  input logic way, input logic [1:0] fw);
        exp_t e = '0;
        if (fill) e = f_fill(way, fw);
        e.stall = 1; e.mem_rd = 1; e.mem_word = iw;
        return e;
    endfunction

    function automatic exp_t f_wb(input logic way, input logic [1:0] w);
        exp_t e = '0;
        e.stall = 1; e.mem_wr = 1; e.way_sel = way;
        e.word_sel = w; e.mem_word = w;
        return e;
    endfunction

    initial begin
        exp_t e;
        rst = 0;
        clr_in();
        @(posedge clk);
        #1;
        do_reset();

        // read hit on way 1, then write hit on way 0
        rd = 1; hit_way = 2'b10; valid_way = 2'b11; cpu_word = 1;
        e = '0; e.comp = 1; e.word_sel = 1; e.cache_hit = 1; e.done = 1;
        e.lru_upd = 1; e.way_sel = 1;
        step(0, e);
        rd = 0; wr = 1; hit_way = 2'b01; valid_way = 2'b01; cpu_word = 3;
        e = '0; e.comp = 1; e.word_sel = 3; e.cache_hit = 1; e.done = 1;
        e.lru_upd = 1; e.way_sel = 0; e.cache_wr = 1; e.dirty_in = 1; e.valid_in = 1;
        step(0, e);

        // read miss, way 1 invalid -> fill way 1 without writeback
        do_reset();
        rd = 1; valid_way = 2'b01; cpu_word = 2;
        step(0, f_miss(2));
        step(0, f_rq(0, 0, 0, 0));
        mem_rvalid = 1;
        step(0, f_rq(1, 1, 1, 0));
        step(0, f_rq(2, 1, 1, 1));
        step(0, f_rq(3, 1, 1, 2));
        step(0, f_fill(1, 3));
        mem_rvalid = 0;
        e = '0; e.done = 1; e.lru_upd = 1; e.way_sel = 1;
        step(0, e);
        clr_in();
        step(0, '0);

        // dirty write miss: writeback with 3-cycle stall on beat 2, refill, CPU write
        do_reset();
        wr = 1; cpu_word = 1; valid_way = 2'b11; dirty_way = 2'b11; lru_way = 0;
        step(0, f_miss(1));
        step(0, f_wb(0, 0));
        step(0, f_wb(0, 1));
        mem_stall = 1;
        repeat (3) step(0, f_wb(0, 2));
        mem_stall = 0;
        step(0, f_wb(0, 2));
        step(0, f_wb(0, 3));
        step(0, f_rq(0, 0, 0, 0));
        mem_rvalid = 1;
        step(0, f_rq(1, 1, 0, 0));
        step(0, f_rq(2, 1, 0, 1));
        step(0, f_rq(3, 1, 0, 2));
        step(0, f_fill(0, 3));
        mem_rvalid = 0;
        e = '0; e.stall = 1; e.cache_wr = 1; e.valid_in = 1; e.dirty_in = 1;
        e.word_sel = 1; e.way_sel = 0; e.done = 1; e.lru_upd = 1;
        step(0, e);
        clr_in();
        step(0, '0);

        // write-no-allocate instance: write miss with 2 stalled cycles
        do_reset();
        wr = 1; cpu_word = 2; valid_way = 2'b01;
        step(1, f_miss(2));
        mem_stall = 1;
        e = '0; e.mem_wr = 1; e.mem_word = 2; e.stall = 1;
        step(1, e);
        step(1, e);
        mem_stall = 0;
        e = '0; e.mem_wr = 1; e.mem_word = 2; e.done = 1;
        step(1, e);
        clr_in();
        step(1, '0);

        // victim from LRU when all ways valid, clean victim -> no writeback
        do_reset();
        rd = 1; valid_way = 2'b11; dirty_way = 2'b01; lru_way = 1; cpu_word = 3;
        step(0, f_miss(3));
        step(0, f_rq(0, 0, 0, 0));
        mem_rvalid = 1;
        step(0, f_rq(1, 1, 1, 0));

        // reset in RW after two fills, then rd&wr error in IDLE
        do_reset();
        rd = 1;
        step(0, f_miss(0));
        step(0, f_rq(0, 0, 0, 0));
        mem_rvalid = 1;
        step(0, f_rq(1, 1, 0, 0));
        step(0, f_rq(2, 1, 0, 1));
        mem_rvalid = 0;
        step(0, f_rq(3, 0, 0, 0));
        e = '0; e.stall = 1;
        step(0, e);
        rst = 0; rd = 0;
        step(0, '0);
        rst = 1;
        step(0, '0);
        rd = 1; wr = 1;
        e = '0; e.err = 1;
        step(0, e);
        rd = 0; wr = 0;
        step(0, '0);
        step(1, '0);

        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain left=%0d exp 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
